cache_2way_wb: RTL and testbench

CACHE_2WAY_WB -- requirements
Module: cache_2way_wb

---
 rtl/cache_2way_wb.sv | 213 +++++++++++++++++++++
 tb/tb_cache_2way_wb.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_wb.sv
// Two-way set-associative, write-back, write-allocate cache with one word
// per line and a variable-latency memory handshake. A request is accepted
// in IDLE, looked up in TAG, optionally writes back a dirty victim (WB),
// refills the line on a miss (FILL) and answers for one cycle in RESP.
module cache_2way_wb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SETS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              hit,
  output logic              ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Registered copy of the request being serviced
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // Way being accessed (hit way or chosen victim) and whether TAG hit
  logic              way_q, way_d;
  logic              hit_q, hit_d;

  // Line state; valid/dirty/lru are reset, tag/data are not
  logic [1:0][SETS-1:0]             valid_q, valid_d;
  logic [1:0][SETS-1:0]             dirty_q, dirty_d;
  logic [SETS-1:0]                  lru_q, lru_d;
  logic [1:0][SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [1:0][SETS-1:0][DATA_W-1:0] data_q, data_d;

  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1;
  logic             victim;
  logic             victim_dirty;

  assign idx     = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:IDX_W];

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;

  // Tag compare and victim choice for the registered request
  always_comb begin
    hit0 = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
    hit1 = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
    if (!valid_q[0][idx]) begin
      victim = 1'b0;
    end else if (!valid_q[1][idx]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[idx];
    end
    victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
  end

  // Next-state, array updates and outputs of the controller
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    way_d        = way_q;
    hit_d        = hit_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    tag_d        = tag_q;
    data_d       = data_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    ready        = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    hit          = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (hit0 || hit1) begin
          hit_d       = 1'b1;
          way_d       = hit1 && !hit0;
          hit_count_d = hit_count_q + 32'd1;
          state_d     = S_RESP;
        end else begin
          hit_d        = 1'b0;
          way_d        = victim;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = victim_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[way_q][idx], idx};
        mem_wdata = data_q[way_q][idx];
        if (mem_ack) begin
          wb_count_d = wb_count_q + 32'd1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          valid_d[way_q][idx] = 1'b1;
          dirty_d[way_q][idx] = 1'b0;
          tag_d[way_q][idx]   = req_tag;
          data_d[way_q][idx]  = mem_rdata;
          state_d             = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        hit        = hit_q;
        if (rw_q) begin
          data_d[way_q][idx]  = wdata_q;
          dirty_d[way_q][idx] = 1'b1;
          resp_rdata          = wdata_q;
        end else begin
          resp_rdata = data_q[way_q][idx];
        end
        lru_d[idx] = ~way_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, line status bits and counters, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      way_q        <= 1'b0;
      hit_q        <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      way_q        <= way_d;
      hit_q        <= hit_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      lru_q        <= lru_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  // Tag and data storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_cache_2way_wb.sv
// Testbench for cache_2way_wb: a transaction-level cache model plus a
// bench-side main memory; every response must return the most recent value
// the CPU stored at that address, and every memory operation must match the
// write-back / refill the model predicts.
module tb_cache_2way_wb;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int SETS   = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              hit;
  logic              ready;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
  logic [31:0]       wb_count;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  cache_2way_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .hit(hit), .ready(ready),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got nothing, required an event", name);
  endtask

  // Main memory seen by the cache, and the value the CPU should observe
  logic [7:0] mem_arr [256];
  logic [7:0] truth   [256];

  // Transaction-level cache model
  bit mv [2][SETS];
  bit md [2][SETS];
  int mt [2][SETS];
  int mlru [SETS];
  int m_hits, m_misses, m_wbs;

  typedef struct { bit we; int addr; int wdata; } op_t;
  typedef struct { bit hit; int rdata; } resp_t;
  op_t   exp_ops [$];
  op_t   txn_ops [$];
  resp_t exp_resp [$];

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      mv[0][s] = 0; mv[1][s] = 0; md[0][s] = 0; md[1][s] = 0; mlru[s] = 0;
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
    for (int a = 0; a < 256; a++) truth[a] = mem_arr[a];
    exp_ops.delete();
    exp_resp.delete();
  endtask

  task automatic predict(input bit rw, input int addr, input int wdata);
    int idx, tag, way, hw;
    op_t op;
    resp_t r;
    idx = addr % SETS;
    tag = addr / SETS;
    hw  = -1;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && mv[w][idx] && mt[w][idx] == tag) hw = w;
    if (hw >= 0) begin
      m_hits++;
      way = hw;
      r.hit = 1;
    end else begin
      m_misses++;
      r.hit = 0;
      if (!mv[0][idx]) way = 0;
      else if (!mv[1][idx]) way = 1;
      else way = mlru[idx];
      if (mv[way][idx] && md[way][idx]) begin
        op.we = 1; op.addr = mt[way][idx] * SETS + idx; op.wdata = truth[op.addr];
        exp_ops.push_back(op);
        m_wbs++;
      end
      op.we = 0; op.addr = addr; op.wdata = 0;
      exp_ops.push_back(op);
      mv[way][idx] = 1; md[way][idx] = 0; mt[way][idx] = tag;
    end
    if (rw) begin
      md[way][idx] = 1;
      truth[addr] = wdata[7:0];
      r.rdata = wdata;
    end else begin
      r.rdata = truth[addr];
    end
    mlru[idx] = 1 - way;
    exp_resp.push_back(r);
  endtask

  // Memory responder: random or fixed latency, spurious acks while idle,
  // holds the request stable and checks each operation against the model
  int lat_mode = -1;
  bit ack_hold = 0;
  bit idle_ack_all = 0;
  initial begin
    bit active;
    int lat;
    bit cap_we;
    logic [7:0] cap_addr, cap_wdata;
    op_t e, o;
    active = 0; lat = 0; cap_we = 0; cap_addr = 0; cap_wdata = 0;
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_req) begin
        active = 0;
        mem_ack = idle_ack_all ? 1'b1 : ($urandom_range(0, 3) == 0);
        mem_rdata = 8'($urandom);
      end else begin
        if (!active) begin
          active = 1;
          lat = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
        end else begin
          checkOutput("mem_we_stable", mem_we, cap_we);
          checkOutput("mem_addr_stable", mem_addr, cap_addr);
          if (cap_we) checkOutput("mem_wdata_stable", mem_wdata, cap_wdata);
        end
        if (ack_hold || lat > 0) begin
          mem_ack = 0;
          if (!ack_hold) lat--;
          mem_rdata = 8'($urandom);
        end else begin
          mem_ack = 1;
          mem_rdata = mem_arr[mem_addr];
          o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
          txn_ops.push_back(o);
          if (exp_ops.size() == 0) begin
            failNow("unexpected_mem_op");
          end else begin
            e = exp_ops.pop_front();
            checkOutput("mem_op_we", mem_we, e.we);
            checkOutput("mem_op_addr", mem_addr, e.addr);
            if (e.we) checkOutput("mem_op_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          active = 0;
        end
      end
    end
  end

  // Compare process: response content, counters, latency, idle outputs
  int  cyc = 0, busy = 0, acc_cyc = 0, acc_busy = 0;
  bit  last_hit;
  int  last_rdata, last_delta;
  initial begin
    resp_t r;
    last_hit = 0; last_rdata = 0; last_delta = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (mem_req) busy++;
        if (ready) checkOutput("idle_mem_req", mem_req, 0);
        if (ready && req_valid) begin
          acc_cyc = cyc;
          acc_busy = busy;
        end
        if (resp_valid) begin
          if (exp_resp.size() == 0) begin
            failNow("unexpected_resp");
          end else begin
            r = exp_resp.pop_front();
            checkOutput("resp_hit", hit, r.hit);
            checkOutput("resp_rdata", resp_rdata, r.rdata);
            checkOutput("hit_count", hit_count, m_hits);
            checkOutput("miss_count", miss_count, m_misses);
            checkOutput("wb_count", wb_count, m_wbs);
            checkOutput("resp_latency", cyc - acc_cyc, 2 + busy - acc_busy);
            checkOutput("mem_ops_done", exp_ops.size(), 0);
          end
          last_hit = hit;
          last_rdata = resp_rdata;
          last_delta = cyc - acc_cyc;
        end else begin
          checkOutput("quiet_resp", {hit, resp_rdata}, 0);
        end
      end
    end
  end

  task automatic doReset();
    rst = 0;
    #1;
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_resp", {resp_valid, hit, resp_rdata}, 0);
    checkOutput("rst_counters", hit_count | miss_count | wb_count, 0);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    checkOutput("post_rst_ready", ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rw, input int addr, input int wdata, output bit ok);
    int n;
    ok = 0;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) begin
      failNow("timeout_ready");
      doReset();
      return;
    end
    txn_ops.delete();
    req_valid = 1; req_rw = rw; req_addr = 8'(addr); req_wdata = 8'(wdata);
    predict(rw, addr, wdata);
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid) begin
        ok = 1;
        break;
      end
      req_valid = 1'($urandom_range(0, 1));
      req_rw = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (!ok) begin
      failNow("timeout_resp");
      doReset();
      return;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    rst = 0; req_valid = 0; req_rw = 0; req_addr = 0; req_wdata = 0;
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'($urandom);
    mem_arr[8'h10] = 8'hA5;
    doReset();

    // Cold read, then repeat hit
    lat_mode = 2;
    applyStimulus(0, 'h10, 0, ok);
    checkOutput("cold_hit", last_hit, 0);
    checkOutput("cold_rdata", last_rdata, 'hA5);
    checkOutput("cold_miss_count", miss_count, 1);
    checkOutput("cold_ops", txn_ops.size(), 1);
    if (txn_ops.size() > 0) checkOutput("cold_fill", {txn_ops[0].we, 8'(txn_ops[0].addr)}, 'h010);
    applyStimulus(0, 'h10, 0, ok);
    checkOutput("rep_hit", last_hit, 1);
    checkOutput("rep_rdata", last_rdata, 'hA5);
    checkOutput("rep_hit_count", hit_count, 1);
    checkOutput("rep_latency", last_delta, 2);
    checkOutput("rep_ops", txn_ops.size(), 0);

    // Dirty LRU eviction
    lat_mode = -1;
    applyStimulus(1, 'h10, 'h3C, ok);
    checkOutput("wr_hit", last_hit, 1);
    checkOutput("wr_echo", last_rdata, 'h3C);
    applyStimulus(0, 'h14, 0, ok);
    checkOutput("rd14_hit", last_hit, 0);
    applyStimulus(0, 'h18, 0, ok);
    checkOutput("rd18_hit", last_hit, 0);
    checkOutput("evict_wb_count", wb_count, 1);
    checkOutput("evict_ops", txn_ops.size(), 2);
    if (txn_ops.size() > 1) begin
      checkOutput("evict_wb", {txn_ops[0].we, 8'(txn_ops[0].addr), 8'(txn_ops[0].wdata)}, 'h1103C);
      checkOutput("evict_fill", {txn_ops[1].we, 8'(txn_ops[1].addr)}, 'h018);
    end

    // LRU ordering
    applyStimulus(0, 'h20, 0, ok);
    applyStimulus(0, 'h24, 0, ok);
    applyStimulus(0, 'h20, 0, ok);
    checkOutput("lru_20_hit", last_hit, 1);
    applyStimulus(0, 'h28, 0, ok);
    checkOutput("lru_28_hit", last_hit, 0);
    checkOutput("lru_28_ops", txn_ops.size(), 1);
    applyStimulus(0, 'h20, 0, ok);
    checkOutput("lru_20_again", last_hit, 1);
    applyStimulus(0, 'h24, 0, ok);
    checkOutput("lru_24_evicted", last_hit, 0);
    checkOutput("lru_hit_count", hit_count, 4);
    checkOutput("lru_miss_count", miss_count, 7);

    // Spurious acks while idle are ignored
    idle_ack_all = 1;
    repeat (20) @(posedge clk);
    #1;
    idle_ack_all = 0;
    checkOutput("idle_ack_hits", hit_count, 4);
    checkOutput("idle_ack_misses", miss_count, 7);
    checkOutput("idle_ack_wbs", wb_count, 1);
    checkOutput("idle_ready", ready, 1);

    // Reset in the middle of a refill
    ack_hold = 1;
    req_valid = 1; req_rw = 0; req_addr = 8'h30; req_wdata = 0;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("fill_pending_req", {mem_req, mem_we, mem_addr}, 'h230);
    doReset();
    ack_hold = 0;
    applyStimulus(0, 'h30, 0, ok);
    checkOutput("reread_hit", last_hit, 0);
    checkOutput("reread_miss_count", miss_count, 1);
    checkOutput("reread_hit_count", hit_count, 0);

    // Randomized traffic over a small address pool
    for (int t = 0; t < 400; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 5) * SETS + $urandom_range(0, SETS - 1),
                    $urandom_range(0, 255), ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failNow("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
